// File: rtl/vram_if.sv
// vram_if -- VRAM arbiter and bus-master region router.
//
// Connects a 6502 bus-master port and a video-composer fetch port to one
// synchronous VRAM (32-bit words, byte write enables, one-cycle read
// latency). Bus-master addresses with bm_addr[19:17] != 0 are forwarded
// to a pass-through I/O port instead.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   bm_addr/wrdata      bus-master byte address / write data
//   bm_strobe/write     single-cycle access request, write qualifier
//   bm_rddata           read data, valid the cycle after a read strobe,
//                       then held until the next read completes
//   fetch_addr/strobe   composer word request, held until fetch_ack
//   fetch_ack           request granted this cycle
//   fetch_rddata/valid  fetched word, valid pulse one cycle after ack
//   ram_*               VRAM port (address, write data, byte enables,
//                       write, read data one cycle after address)
//   io_*                I/O pass-through port (io_rddata sampled the
//                       cycle after io_strobe)
//
// Optional feature (macro VRAMIF_STALL_COUNT_EN):
//   stall_cnt_clr       clears the stall counter (wins over increment)
//   fetch_stall_cnt     saturating count of cycles with fetch_strobe=1
//                       and fetch_ack=0
//
// Every output reads 0 while rst_n is low.
module vram_if #(
  parameter int VRAM_WORD_AW = 15,
  parameter int STALL_CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [19:0]             bm_addr,
  input  logic [7:0]              bm_wrdata,
  input  logic                    bm_strobe,
  input  logic                    bm_write,
  output logic [7:0]              bm_rddata,
  input  logic [VRAM_WORD_AW-1:0] fetch_addr,
  input  logic                    fetch_strobe,
  output logic                    fetch_ack,
  output logic [31:0]             fetch_rddata,
  output logic                    fetch_valid,
  output logic [VRAM_WORD_AW-1:0] ram_addr,
  output logic [31:0]             ram_wrdata,
  output logic [3:0]              ram_wrbytesel,
  output logic                    ram_write,
  input  logic [31:0]             ram_rddata,
  output logic [16:0]             io_addr,
  output logic [7:0]              io_wrdata,
  output logic                    io_strobe,
  output logic                    io_write,
  input  logic [7:0]              io_rddata
`ifdef VRAMIF_STALL_COUNT_EN
  ,
  input  logic                    stall_cnt_clr,
  output logic [STALL_CNT_W-1:0]  fetch_stall_cnt
`endif
);

  logic                    is_io_p0;
  logic                    bm_vram_p0;
  logic                    bm_io_p0;
  logic [VRAM_WORD_AW-1:0] addr_mux_p0;
  logic                    grant_fetch_p0;

  logic                    rd_vld_p1;
  logic                    rd_io_p1;
  logic [1:0]              rd_lane_p1;
  logic [7:0]              rd_hold_p1;
  logic [7:0]              rd_byte_p1;
  logic                    fetch_vld_p1;
  logic [31:0]             fetch_hold_p1;
  logic [VRAM_WORD_AW-1:0] addr_hold_p1;

  // Stage p0: region decode and port arbitration (combinational)
  assign is_io_p0   = |bm_addr[19:17];
  assign bm_vram_p0 = bm_strobe & ~is_io_p0;
  assign bm_io_p0   = bm_strobe & is_io_p0;

  // A CPU VRAM access always wins; the composer is served otherwise.
  // With no request the RAM address parks on its last value.
  always_comb begin
    addr_mux_p0    = addr_hold_p1;
    grant_fetch_p0 = 1'b0;
    if (bm_vram_p0) begin
      addr_mux_p0 = bm_addr[VRAM_WORD_AW+1:2];
    end else if (fetch_strobe) begin
      addr_mux_p0    = fetch_addr;
      grant_fetch_p0 = 1'b1;
    end
  end

  always_comb begin
    ram_addr      = '0;
    ram_wrdata    = '0;
    ram_wrbytesel = '0;
    ram_write     = 1'b0;
    fetch_ack     = 1'b0;
    io_addr       = '0;
    io_wrdata     = '0;
    io_write      = 1'b0;
    io_strobe     = 1'b0;
    if (rst_n) begin
      ram_addr  = addr_mux_p0;
      fetch_ack = grant_fetch_p0;
      if (bm_vram_p0 && bm_write) begin
        ram_write     = 1'b1;
        ram_wrdata    = {4{bm_wrdata}};
        ram_wrbytesel = 4'b0001 << bm_addr[1:0];
      end
      io_addr   = bm_addr[16:0];
      io_wrdata = bm_wrdata;
      io_write  = bm_write;
      io_strobe = bm_io_p0;
    end
  end

  // Stage p1: read/fetch tracking registers, RAM data returns this stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_p1     <= 1'b0;
      rd_io_p1      <= 1'b0;
      rd_lane_p1    <= '0;
      rd_hold_p1    <= '0;
      fetch_vld_p1  <= 1'b0;
      fetch_hold_p1 <= '0;
      addr_hold_p1  <= '0;
    end else begin
      rd_vld_p1    <= bm_strobe & ~bm_write;
      rd_io_p1     <= is_io_p0;
      rd_lane_p1   <= bm_addr[1:0];
      fetch_vld_p1 <= grant_fetch_p0;
      addr_hold_p1 <= addr_mux_p0;
      if (rd_vld_p1) begin
        rd_hold_p1 <= rd_byte_p1;
      end
      if (fetch_vld_p1) begin
        fetch_hold_p1 <= ram_rddata;
      end
    end
  end

  // Read data is steered straight from the inputs in the return cycle so
  // the CPU sees it with exactly one cycle of latency; the hold registers
  // keep the value visible afterwards.
  assign rd_byte_p1   = rd_io_p1 ? io_rddata : ram_rddata[8*rd_lane_p1 +: 8];
  assign bm_rddata    = rd_vld_p1 ? rd_byte_p1 : rd_hold_p1;
  assign fetch_valid  = fetch_vld_p1;
  assign fetch_rddata = fetch_vld_p1 ? ram_rddata : fetch_hold_p1;

`ifdef VRAMIF_STALL_COUNT_EN
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p1: stall counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_stall_cnt <= '0;
    end else if (stall_cnt_clr) begin
      fetch_stall_cnt <= '0;
    end else if (fetch_strobe && !grant_fetch_p0) begin
      fetch_stall_cnt <= sat_inc(fetch_stall_cnt);
    end
  end
`endif

endmodule

// File: doc/vram_if.md
Name: vram_if

Overview:
- Downstream consumer of the 6502 bus-interface bus-master port.
- Arbitrates CPU byte accesses against 32-bit video-composer fetches onto one synchronous 128 KB VRAM (32-bit words, byte write enables).
- Routes bus-master addresses at or above 0x20000 to a pass-through I/O port.
- Returns CPU read data with fixed one-cycle latency, as the bus interface requires.

Parameters:
- VRAM_WORD_AW, 15, VRAM word-address width; VRAM byte space = 4 << VRAM_WORD_AW.
- STALL_CNT_W, 16, width of the optional stall counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- bm_addr  in  20  bus-master byte address
- bm_wrdata  in  8  bus-master write data
- bm_strobe  in  1  single-cycle access request
- bm_write  in  1  1 = write, qualifies bm_strobe
- bm_rddata  out  8  read data, valid in the cycle after a read strobe
- fetch_addr  in  VRAM_WORD_AW  composer word address
- fetch_strobe  in  1  request, held until fetch_ack
- fetch_ack  out  1  request granted this cycle
- fetch_rddata  out  32  fetched word
- fetch_valid  out  1  fetch_rddata valid pulse
- ram_addr  out  VRAM_WORD_AW  VRAM word address
- ram_wrdata  out  32  VRAM write data
- ram_wrbytesel  out  4  byte write enables
- ram_write  out  1  VRAM write
- ram_rddata  in  32  VRAM read data, one cycle after address
- io_addr  out  17  bm_addr[16:0] pass-through
- io_wrdata  out  8  pass-through
- io_strobe  out  1  bm_strobe qualified by I/O region
- io_write  out  1  pass-through
- io_rddata  in  8  I/O read data, sampled the cycle after io_strobe

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low. All registers clear on reset; every output reads 0 during reset.
- Region decode: VRAM if bm_addr[19:17]==0, else I/O. io_strobe = bm_strobe & I/O region, combinational. io_addr, io_wrdata and io_write are combinational pass-throughs.
- Arbitration, per cycle:
  - A bus-master VRAM strobe always wins.
  - Otherwise fetch_strobe is granted: fetch_ack=1, ram_addr=fetch_addr, ram_write=0.
  - With no request, ram_addr holds its last value and ram_write=0.
- CPU VRAM write:
  - ram_write=1, ram_addr=bm_addr[VRAM_WORD_AW+1:2].
  - ram_wrdata={4{bm_wrdata}}, ram_wrbytesel=1<<bm_addr[1:0].
  - Same cycle as strobe, no buffering.
- CPU read pipeline:
  - Register rd_pend, region flag and bm_addr[1:0].
  - In the next cycle, bm_rddata = selected byte of ram_rddata (VRAM) or io_rddata (I/O), combinational from the inputs.
  - The value is then captured into a hold register; bm_rddata shows the hold register when rd_pend=0.
  - Writes do not update the hold register.
- Fetch: fetch_valid=1 exactly one cycle after fetch_ack, with fetch_rddata=ram_rddata; held in a register afterwards.
- Composer contract: holds fetch_strobe and fetch_addr stable until ack; may change fetch_addr in the ack cycle.
- Back-to-back CPU strobes: each is served in its own cycle; fetch is stalled for the whole run.
- Same-cycle CPU write and fetch to the same word: write first, fetch granted next cycle, returns the new byte.
- Consecutive fetches: ack may be asserted every cycle; throughput 1 word/cycle.
- Reset mid-operation: pending CPU read and fetch are dropped; no fetch_valid after reset release until a new ack.
- Address arithmetic is pure bit slicing; no wrap logic is needed.

Optional Feature:
- Macro VRAMIF_STALL_COUNT_EN.
- When defined: adds output fetch_stall_cnt [STALL_CNT_W-1:0].
  - Increments each cycle fetch_strobe=1 and fetch_ack=0; saturates at all-ones.
  - Cleared by reset and by input stall_cnt_clr (1 bit). Clear wins over a same-cycle increment.
- When undefined: neither port nor logic exists; behaviour is otherwise identical.

Test Plan:
- Write bm_addr=0x00006, data 0xA5 → ram_write=1, ram_addr=1, wrbytesel=4'b0100, wrdata=0xA5A5A5A5. Then read 0x00006 → bm_rddata=0xA5 the next cycle, and still 0xA5 two cycles later.
- Hold fetch_strobe, fetch_addr=0x0001, and pulse a bm write in the same cycle → fetch_ack=0 that cycle, 1 the next. fetch_valid follows one cycle later with the updated byte in lane 2.
- Read bm_addr=0x20010 with io_rddata=0x3C → io_strobe=1, io_addr=0x00010, ram untouched, bm_rddata=0x3C one cycle later.
- Fetch addresses 0,1,2 on consecutive cycles with no CPU traffic → three acks, three consecutive fetch_valid pulses with matching words.
- Assert rst_n=0 in the cycle after a fetch_ack → no fetch_valid, all outputs 0; after release bm_rddata=0.
- With VRAMIF_STALL_COUNT_EN: 5 back-to-back CPU strobes against a held fetch → count=5; pulse stall_cnt_clr → 0; preset the counter near max → saturates at 0xFFFF.
